// File: rtl/core_pkg.sv
// Shared core definitions: default widths, register-address type, zero-register index.
package core_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NREGS_DEF);
  localparam int unsigned ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_bits.sv
// Per-register busy scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_sb_bits
  import core_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,   // caller guarantees set_idx is a valid, non-zero register
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,   // caller guarantees clr_idx is a valid, non-zero register
  input  logic [ADDR_W-1:0] clr_idx,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next scoreboard state: clear first, then set, so a new producer supersedes a retiring one.
  always_comb begin
    // NOTE: blocking assignments here are evaluated in order, which is what gives set priority over clear.
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_scoreboard_bp.sv
// Integer register file with two combinational read ports, one write port,
// optional write-to-read bypass and a busy scoreboard for hazard detection.
module regfile_scoreboard_bp
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = $clog2(NREGS),
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [XLEN-1:0]   rd_data1,
  output logic [XLEN-1:0]   rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [NREGS-1:0]  busy_vec
);

  // A register address is usable only if it is neither r0 nor beyond the implemented range.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return (32'(a) != ZERO_REG) && (32'(a) < unsigned'(NREGS));
  endfunction

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic wr_ok, iss_ok;
  logic rd_ok1, rd_ok2;
  logic fwd1, fwd2;
  logic iss_hit1, iss_hit2;

  assign wr_ok    = wr_en && addr_valid(wr_addr);
  assign iss_ok   = issue_en && addr_valid(issue_rd);
  assign rd_ok1   = addr_valid(rd_addr1);
  assign rd_ok2   = addr_valid(rd_addr2);
  assign fwd1     = BYPASS && wr_en && (wr_addr == rd_addr1);
  assign fwd2     = BYPASS && wr_en && (wr_addr == rd_addr2);
  assign iss_hit1 = issue_en && (issue_rd == rd_addr1);
  assign iss_hit2 = issue_en && (issue_rd == rd_addr2);

  // Next array contents: one register replaced on a valid writeback, r0 pinned to zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end

  // Data array storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is reset on purpose so reads never return X after reset.
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: zero for r0/out-of-range, forwarded write data when bypassing, else the array.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_ok1) rd_data1 = fwd1 ? wr_data : regs_q[rd_addr1];
    if (rd_ok2) rd_data2 = fwd2 ? wr_data : regs_q[rd_addr2];
  end

  regfile_sb_bits #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (iss_ok),
    .set_idx  (issue_rd),
    .clr_en   (wr_ok),
    .clr_idx  (wr_addr),
    .busy_vec (busy_vec)
  );

  // Source busy flags: a forwarded value is not a hazard unless a newer producer issues now.
  always_comb begin
    rd_busy1 = 1'b0;
    rd_busy2 = 1'b0;
    if (rd_ok1) rd_busy1 = busy_vec[rd_addr1] && !(fwd1 && !iss_hit1);
    if (rd_ok2) rd_busy2 = busy_vec[rd_addr2] && !(fwd2 && !iss_hit2);
  end

endmodule

// File: tb/tb_regfile_scoreboard_bp.sv
// Self-checking bench: three instances (bypass, no bypass, 24 registers) share one stimulus stream.
module tb_regfile_scoreboard_bp;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  reg_addr_t   rd_addr1, rd_addr2, wr_addr, issue_rd;
  logic        wr_en, issue_en;
  logic [31:0] wr_data;

  logic [31:0] d1_a, d2_a, d1_n, d2_n, d1_s, d2_s;
  logic        b1_a, b2_a, b1_n, b2_n, b1_s, b2_s;
  logic [31:0] vec_a, vec_n;
  logic [23:0] vec_s;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = bypass/32 regs, 1 = no bypass/32 regs, 2 = bypass/24 regs.
  logic [31:0] m_regs [3][32];
  bit          m_busy [3][32];

  always #5 clk = ~clk;

  regfile_scoreboard_bp #(.NREGS(32), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_a), .rd_data2(d2_a), .rd_busy1(b1_a), .rd_busy2(b2_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(vec_a));

  regfile_scoreboard_bp #(.NREGS(32), .BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_n), .rd_data2(d2_n), .rd_busy1(b1_n), .rd_busy2(b2_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(vec_n));

  regfile_scoreboard_bp #(.NREGS(24), .BYPASS(1'b1)) dut_s (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_s), .rd_data2(d2_s), .rd_busy1(b1_s), .rd_busy2(b2_s),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .busy_vec(vec_s));

  function automatic int nregs_of(input int k);
    return (k == 2) ? 24 : 32;
  endfunction

  function automatic bit byp_of(input int k);
    return (k != 1);
  endfunction

  function automatic bit in_range(input int k, input int a);
    return (a != 0) && (a < nregs_of(k));
  endfunction

  // Expected read data from the architectural rules, using the currently driven inputs.
  function automatic logic [31:0] exp_data(input int k, input int a);
    if (!in_range(k, a)) return 32'h0;
    if (byp_of(k) && wr_en && int'(wr_addr) == a) return wr_data;
    return m_regs[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input int a);
    if (!in_range(k, a)) return 1'b0;
    if (byp_of(k) && wr_en && int'(wr_addr) == a && !(issue_en && int'(issue_rd) == a)) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic logic [31:0] exp_vec(input int k);
    logic [31:0] v = '0;
    for (int i = 0; i < nregs_of(k); i++) v[i] = m_busy[k][i];
    return v;
  endfunction

  // Advance the reference state by one clock edge.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int i = 0; i < 32; i++) begin
          m_regs[k][i] = '0;
          m_busy[k][i] = 1'b0;
        end
      end else begin
        if (wr_en && in_range(k, int'(wr_addr))) begin
          m_regs[k][wr_addr] = wr_data;
          m_busy[k][wr_addr] = 1'b0;
        end
        if (issue_en && in_range(k, int'(issue_rd))) m_busy[k][issue_rd] = 1'b1;
      end
    end
  endtask

  // Commit the previous inputs at the rising edge, then drive new inputs mid-cycle.
  task automatic cyc(input logic r, input logic we, input int wa, input logic [31:0] wd,
                     input logic ie, input int ir, input int a1, input int a2);
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset    = r;
    wr_en    = we;
    wr_addr  = reg_addr_t'(wa);
    wr_data  = wd;
    issue_en = ie;
    issue_rd = reg_addr_t'(ir);
    rd_addr1 = reg_addr_t'(a1);
    rd_addr2 = reg_addr_t'(a2);
    #1;
  endtask

  task automatic sample(input int k, output logic [31:0] od1, output logic [31:0] od2,
                        output logic ob1, output logic ob2, output logic [31:0] ov);
    case (k)
      0:       begin od1 = d1_a; od2 = d2_a; ob1 = b1_a; ob2 = b2_a; ov = vec_a; end
      1:       begin od1 = d1_n; od2 = d2_n; ob1 = b1_n; ob2 = b2_n; ov = vec_n; end
      default: begin od1 = d1_s; od2 = d2_s; ob1 = b1_s; ob2 = b2_s; ov = {8'h0, vec_s}; end
    endcase
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0, 0, 0, i, 31 - i);
      checks++; if (d1_a !== 32'h0) begin errors++; $display("FAIL reset_rd1 addr=%0d got=%h exp=0", i, d1_a); end
      checks++; if (d2_a !== 32'h0) begin errors++; $display("FAIL reset_rd2 addr=%0d got=%h exp=0", 31 - i, d2_a); end
      checks++; if ({b1_a, b2_a, b1_s, b2_s} !== 4'b0) begin errors++; $display("FAIL reset_busy addr=%0d got=%b exp=0000", i, {b1_a, b2_a, b1_s, b2_s}); end
    end
    checks++; if (vec_a !== 32'h0 || vec_n !== 32'h0 || vec_s !== 24'h0) begin errors++; $display("FAIL reset_vec got=%h/%h/%h exp=0", vec_a, vec_n, vec_s); end
  endtask

  task automatic test_write_read();
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 5, 0);
    checks++; if (d1_a !== 32'hDEADBEEF) begin errors++; $display("FAIL write_r5 got=%h exp=deadbeef", d1_a); end
    checks++; if (d1_n !== 32'hDEADBEEF) begin errors++; $display("FAIL write_r5_nobyp got=%h exp=deadbeef", d1_n); end
    cyc(0, 1, 0, 32'h1234, 0, 0, 0, 0);
    checks++; if (d1_a !== 32'h0) begin errors++; $display("FAIL write_r0_same got=%h exp=0", d1_a); end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (d1_a !== 32'h0 || d2_n !== 32'h0) begin errors++; $display("FAIL write_r0_after got=%h/%h exp=0", d1_a, d2_n); end
  endtask

  task automatic test_bypass();
    cyc(0, 1, 7, 32'h1111_1111, 1, 7, 0, 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 7);
    checks++; if (d2_a !== 32'h1111_1111 || b2_a !== 1'b1) begin errors++; $display("FAIL byp_setup got=%h/%b exp=11111111/1", d2_a, b2_a); end
    cyc(0, 1, 7, 32'hA5A5_A5A5, 0, 0, 0, 7);
    checks++; if (d2_a !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_data got=%h exp=a5a5a5a5", d2_a); end
    checks++; if (b2_a !== 1'b0) begin errors++; $display("FAIL byp_busy got=%b exp=0", b2_a); end
    checks++; if (d2_n !== 32'h1111_1111) begin errors++; $display("FAIL nobyp_data got=%h exp=11111111", d2_n); end
    checks++; if (b2_n !== 1'b1) begin errors++; $display("FAIL nobyp_busy got=%b exp=1", b2_n); end
    cyc(0, 0, 0, 0, 0, 0, 0, 7);
    checks++; if (d2_a !== 32'hA5A5_A5A5 || d2_n !== 32'hA5A5_A5A5 || b2_a !== 1'b0) begin errors++; $display("FAIL byp_after got=%h/%h/%b exp=a5a5a5a5/a5a5a5a5/0", d2_a, d2_n, b2_a); end
    cyc(0, 0, 0, 0, 1, 7, 0, 0);
    cyc(0, 1, 7, 32'hBBBB_0000, 1, 7, 0, 7);
    checks++; if (b2_a !== 1'b1 || d2_a !== 32'hBBBB_0000) begin errors++; $display("FAIL byp_reissue got=%b/%h exp=1/bbbb0000", b2_a, d2_a); end
    cyc(0, 1, 7, 32'hBBBB_0000, 0, 0, 0, 0);
  endtask

  task automatic test_set_clear_same();
    cyc(0, 0, 0, 0, 1, 3, 3, 0);
    cyc(0, 1, 3, 32'h33, 1, 3, 3, 0);
    checks++; if (vec_a[3] !== 1'b1) begin errors++; $display("FAIL sb_issue got=%b exp=1", vec_a[3]); end
    cyc(0, 1, 3, 32'h44, 0, 0, 3, 0);
    checks++; if (vec_a[3] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b exp=1", vec_a[3]); end
    cyc(0, 0, 0, 0, 0, 0, 3, 0);
    checks++; if (vec_a[3] !== 1'b0 || d1_a !== 32'h44) begin errors++; $display("FAIL sb_clear got=%b/%h exp=0/44", vec_a[3], d1_a); end
  endtask

  task automatic test_set_clear_diff();
    cyc(0, 0, 0, 0, 1, 4, 0, 0);
    cyc(0, 1, 4, 32'h4, 1, 9, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (vec_a[9] !== 1'b1 || vec_a[4] !== 1'b0) begin errors++; $display("FAIL sb_diff got=%b%b exp=10", vec_a[9], vec_a[4]); end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (vec_a !== 32'h0000_0200) begin errors++; $display("FAIL sb_r0 got=%h exp=00000200", vec_a); end
    cyc(0, 1, 9, 32'h9, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midstream();
    for (int i = 1; i < 32; i++) cyc(0, 1, i, $urandom, 1, i, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (vec_a !== 32'hFFFF_FFFE || vec_s !== 24'hFF_FFFE) begin errors++; $display("FAIL fill_vec got=%h/%h exp=fffffffe/fffffe", vec_a, vec_s); end
    cyc(1, 1, 5, 32'hFFFF_FFFF, 1, 6, 5, 6);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (vec_a !== 32'h0 || vec_n !== 32'h0 || vec_s !== 24'h0) begin errors++; $display("FAIL midreset_vec got=%h/%h/%h exp=0", vec_a, vec_n, vec_s); end
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0, 0, 0, i, 31 - i);
      checks++; if (d1_a !== 32'h0 || d2_a !== 32'h0 || d1_s !== 32'h0) begin errors++; $display("FAIL midreset_rd addr=%0d got=%h/%h/%h exp=0", i, d1_a, d2_a, d1_s); end
    end
  endtask

  task automatic test_out_of_range();
    cyc(0, 1, 30, 32'hCAFE_F00D, 1, 30, 30, 30);
    checks++; if (d1_s !== 32'h0 || b1_s !== 1'b0) begin errors++; $display("FAIL oor_same got=%h/%b exp=0/0", d1_s, b1_s); end
    cyc(0, 0, 0, 0, 0, 0, 30, 30);
    checks++; if (d1_s !== 32'h0 || b2_s !== 1'b0 || vec_s !== 24'h0) begin errors++; $display("FAIL oor_after got=%h/%b/%h exp=0/0/0", d1_s, b2_s, vec_s); end
    checks++; if (d1_a !== 32'hCAFE_F00D || b1_a !== 1'b1) begin errors++; $display("FAIL oor_full got=%h/%b exp=cafef00d/1", d1_a, b1_a); end
  endtask

  task automatic test_random();
    logic [31:0] od1, od2, ov;
    logic        ob1, ob2;
    int          a1, a2, wa, ir;
    for (int n = 0; n < 400; n++) begin
      a1 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      a2 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      wa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      ir = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, wa, $urandom,
          $urandom_range(0, 1) == 1, ir, a1, a2);
      for (int k = 0; k < 3; k++) begin
        sample(k, od1, od2, ob1, ob2, ov);
        checks++; if (od1 !== exp_data(k, a1)) begin errors++; $display("FAIL rnd_rd1 dut=%0d n=%0d got=%h exp=%h", k, n, od1, exp_data(k, a1)); end
        checks++; if (od2 !== exp_data(k, a2)) begin errors++; $display("FAIL rnd_rd2 dut=%0d n=%0d got=%h exp=%h", k, n, od2, exp_data(k, a2)); end
        checks++; if (ob1 !== exp_busy(k, a1)) begin errors++; $display("FAIL rnd_busy1 dut=%0d n=%0d got=%b exp=%b", k, n, ob1, exp_busy(k, a1)); end
        checks++; if (ob2 !== exp_busy(k, a2)) begin errors++; $display("FAIL rnd_busy2 dut=%0d n=%0d got=%b exp=%b", k, n, ob2, exp_busy(k, a2)); end
        checks++; if (ov !== exp_vec(k)) begin errors++; $display("FAIL rnd_vec dut=%0d n=%0d got=%h exp=%h", k, n, ov, exp_vec(k)); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; issue_en = 1'b0; wr_data = '0;
    wr_addr = '0; issue_rd = '0; rd_addr1 = '0; rd_addr2 = '0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = '0;
        m_busy[k][i] = 1'b0;
      end
    test_reset();
    test_write_read();
    test_bypass();
    test_set_clear_same();
    test_set_clear_diff();
    test_reset_midstream();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
